dat_crc16_lanes: RTL and testbench

//  Per-lane CRC16 unit on the 4-bit DAT path. It sits between the DAT physical serializer and the card pins.

---
 rtl/dat_crc16_lanes_if.sv | 30 +++
 rtl/dat_crc16_lanes.sv | 131 +++++++++++++
 tb/tb_dat_crc16_lanes.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dat_crc16_lanes_if.sv
// Handshake/data bundle between the DAT serializer side and the per-lane CRC16 unit.
// crc_err_lanes exists only when DAT_CRC_LANE_ERR_EN is defined.
interface dat_crc16_lanes_if #(
  parameter int BLOCK_SZ_WIDTH = 12,
  parameter int LANES          = 4
);
  logic                      start;
  logic                      dir;
  logic [BLOCK_SZ_WIDTH-1:0] block_sz;
  logic                      data_valid;
  logic [LANES-1:0]          data_in;
  logic [LANES-1:0]          crc_out;
  logic                      crc_out_vld;
  logic                      busy;
  logic                      crc_done;
  logic                      crc_err;
`ifdef DAT_CRC_LANE_ERR_EN
  logic [LANES-1:0]          crc_err_lanes;

  modport master (output start, dir, block_sz, data_valid, data_in,
                  input  crc_out, crc_out_vld, busy, crc_done, crc_err, crc_err_lanes);
  modport slave  (input  start, dir, block_sz, data_valid, data_in,
                  output crc_out, crc_out_vld, busy, crc_done, crc_err, crc_err_lanes);
`else
  modport master (output start, dir, block_sz, data_valid, data_in,
                  input  crc_out, crc_out_vld, busy, crc_done, crc_err);
  modport slave  (input  start, dir, block_sz, data_valid, data_in,
                  output crc_out, crc_out_vld, busy, crc_done, crc_err);
`endif
endinterface

// File: rtl/dat_crc16_lanes.sv
// Per-lane CRC16-CCITT generate (write) / check (read) on the 4-bit DAT path.
// Optional macro DAT_CRC_LANE_ERR_EN adds per-lane sticky mismatch flags.
module dat_crc16_lanes #(
  parameter int          BLOCK_SZ_WIDTH = 12,
  parameter int          LANES          = 4,
  parameter logic [15:0] CRC_POLY       = 16'h1021
) (
  input  logic            i_sd_clk,
  input  logic            i_rst,
  dat_crc16_lanes_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_SEND, S_RECV} state_t;

  state_t                     r_state, w_state_nxt;
  logic                       r_dir;
  logic [BLOCK_SZ_WIDTH:0]    r_nib_cnt;
  logic [3:0]                 r_bit_cnt;
  logic                       r_tail;
  logic [LANES-1:0][15:0]     r_crc;
  logic [LANES-1:0][15:0]     w_crc_nxt;
  logic [LANES-1:0]           w_crc_bit;
  logic [LANES-1:0]           w_mis;
  logic [LANES-1:0]           r_crc_out;
  logic                       r_crc_out_vld;
  logic                       r_crc_done;
  logic                       w_last_nib;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_crc_nxt[g] = {r_crc[g][14:0], 1'b0} ^
                          ((r_crc[g][15] ^ bus.data_in[g]) ? CRC_POLY : 16'h0000);
    assign w_crc_bit[g] = r_crc[g][r_bit_cnt];
    assign w_mis[g]     = bus.data_in[g] ^ w_crc_bit[g];
  end

  assign w_last_nib = (r_nib_cnt == (BLOCK_SZ_WIDTH+1)'(1));

  // start is honoured in every state: it aborts any block in flight
  always_comb begin
    w_state_nxt = r_state;
    if (bus.start) begin
      if (bus.block_sz == '0) w_state_nxt = bus.dir ? S_SEND : S_RECV;
      else                    w_state_nxt = S_DATA;
    end else begin
      case (r_state)
        S_DATA: if (bus.data_valid && w_last_nib) w_state_nxt = r_dir ? S_SEND : S_RECV;
        S_SEND: if (r_tail) w_state_nxt = S_IDLE;
        S_RECV: if (bus.data_valid && r_bit_cnt == 4'd0) w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

`ifdef DAT_CRC_LANE_ERR_EN
  logic [LANES-1:0] r_err_lanes;
  assign bus.crc_err_lanes = r_err_lanes;
  assign bus.crc_err       = |r_err_lanes;
`else
  logic r_err;
  assign bus.crc_err = r_err;
`endif

  always_ff @(posedge i_sd_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_dir         <= 1'b0;
      r_nib_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_tail        <= 1'b0;
      r_crc         <= '0;
      r_crc_out     <= '0;
      r_crc_out_vld <= 1'b0;
      r_crc_done    <= 1'b0;
`ifdef DAT_CRC_LANE_ERR_EN
      r_err_lanes   <= '0;
`else
      r_err         <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_crc_done <= 1'b0;
      if (bus.start) begin
        r_dir         <= bus.dir;
        r_nib_cnt     <= {bus.block_sz, 1'b0};
        r_bit_cnt     <= 4'hF;
        r_tail        <= 1'b0;
        r_crc         <= '0;
        r_crc_out     <= '0;
        r_crc_out_vld <= 1'b0;
`ifdef DAT_CRC_LANE_ERR_EN
        r_err_lanes   <= '0;
`else
        r_err         <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_DATA: if (bus.data_valid) begin
            r_crc     <= w_crc_nxt;
            r_nib_cnt <= r_nib_cnt - 1'b1;
          end
          // r_tail marks the extra cycle after bit 0 that drops valid and pulses done
          S_SEND: if (r_tail) begin
            r_crc_out     <= '0;
            r_crc_out_vld <= 1'b0;
            r_crc_done    <= 1'b1;
            r_tail        <= 1'b0;
          end else begin
            r_crc_out     <= w_crc_bit;
            r_crc_out_vld <= 1'b1;
            if (r_bit_cnt == 4'd0) r_tail    <= 1'b1;
            else                   r_bit_cnt <= r_bit_cnt - 1'b1;
          end
          S_RECV: if (bus.data_valid) begin
`ifdef DAT_CRC_LANE_ERR_EN
            r_err_lanes <= r_err_lanes | w_mis;
`else
            r_err       <= r_err | (|w_mis);
`endif
            r_bit_cnt <= r_bit_cnt - 1'b1;
            if (r_bit_cnt == 4'd0) r_crc_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.crc_out     = r_crc_out;
  assign bus.crc_out_vld = r_crc_out_vld;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.crc_done    = r_crc_done;
endmodule

// File: tb/tb_dat_crc16_lanes.sv
// Directed bench for dat_crc16_lanes: write/read CRC, abort, rst and boundary cases.
module tb_dat_crc16_lanes;
  localparam int BW = 12;
  localparam int LN = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dat_crc16_lanes_if #(.BLOCK_SZ_WIDTH(BW), .LANES(LN)) bus_if ();

  dat_crc16_lanes #(.BLOCK_SZ_WIDTH(BW), .LANES(LN), .CRC_POLY(16'h1021)) dut (
    .i_sd_clk (clk),
    .i_rst    (rst),
    .bus      (bus_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic d, input logic [BW-1:0] bsz);
    bus_if.start      = 1'b1;
    bus_if.dir        = d;
    bus_if.block_sz   = bsz;
    bus_if.data_valid = 1'b0;
    tick();
    bus_if.start      = 1'b0;
  endtask

  task automatic feed(input int n, input logic [3:0] nib);
    bus_if.data_valid = 1'b1;
    bus_if.data_in    = nib;
    repeat (n) tick();
    bus_if.data_valid = 1'b0;
  endtask

  task automatic check_send(input logic [15:0] crc, input string tag);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk({tag, "_vld"}, 32'(bus_if.crc_out_vld), 32'd1);
      chk({tag, "_nib"}, 32'(bus_if.crc_out), 32'({4{crc[15-k]}}));
    end
    tick();
    chk({tag, "_done"}, 32'(bus_if.crc_done), 32'd1);
    chk({tag, "_vld_off"}, 32'(bus_if.crc_out_vld), 32'd0);
    chk({tag, "_out_off"}, 32'(bus_if.crc_out), 32'd0);
    chk({tag, "_idle"}, 32'(bus_if.busy), 32'd0);
    tick();
    chk({tag, "_done_1cyc"}, 32'(bus_if.crc_done), 32'd0);
  endtask

  // Read phase: 16 CRC nibbles, lane mask xor'd into nibble index flip_k
  task automatic recv_crc(input logic [15:0] crc, input int flip_k, input logic [3:0] flip_m,
                          input logic exp_err, input string tag);
    bus_if.data_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus_if.data_in = {4{crc[15-k]}} ^ ((k == flip_k) ? flip_m : 4'h0);
      tick();
    end
    bus_if.data_valid = 1'b0;
    bus_if.data_in    = 4'h0;
    chk({tag, "_done"}, 32'(bus_if.crc_done), 32'd1);
    chk({tag, "_err"}, 32'(bus_if.crc_err), 32'(exp_err));
    chk({tag, "_idle"}, 32'(bus_if.busy), 32'd0);
    chk({tag, "_no_vld"}, 32'(bus_if.crc_out_vld), 32'd0);
    tick();
    chk({tag, "_done_1cyc"}, 32'(bus_if.crc_done), 32'd0);
    chk({tag, "_err_hold"}, 32'(bus_if.crc_err), 32'(exp_err));
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.start      = 1'b0;
    bus_if.dir        = 1'b0;
    bus_if.block_sz   = '0;
    bus_if.data_valid = 1'b0;
    bus_if.data_in    = 4'h0;
    tick(); tick();
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_vld", 32'(bus_if.crc_out_vld), 32'd0);
    chk("rst_out", 32'(bus_if.crc_out), 32'd0);
    chk("rst_done", 32'(bus_if.crc_done), 32'd0);
    chk("rst_err", 32'(bus_if.crc_err), 32'd0);
    rst = 1'b0;
    tick();

    // 1: write 2048 bytes of 0xF nibbles -> 16'h7FA1 on every lane
    do_start(1'b1, 12'd2048);
    chk("t1_busy", 32'(bus_if.busy), 32'd1);
    feed(4096, 4'hF);
    chk("t1_pre_send_vld", 32'(bus_if.crc_out_vld), 32'd0);
    check_send(16'h7FA1, "t1");

    // 2: read back same block with correct CRC
    do_start(1'b0, 12'd2048);
    feed(4096, 4'hF);
    recv_crc(16'h7FA1, -1, 4'h0, 1'b0, "t2");

    // 3: lane 0 corrupted on the 5th CRC nibble
    do_start(1'b0, 12'd2048);
    feed(4096, 4'hF);
    recv_crc(16'h7FA1, 4, 4'h1, 1'b1, "t3");
`ifdef DAT_CRC_LANE_ERR_EN
    chk("t3_lanes", 32'(bus_if.crc_err_lanes), 32'h1);
`endif
    tick();
    chk("t3_err_sticky_idle", 32'(bus_if.crc_err), 32'd1);

    // 4: block_sz=4, valid toggling, zero data -> zero CRC; start clears sticky err
    do_start(1'b1, 12'd4);
    chk("t4_err_cleared", 32'(bus_if.crc_err), 32'd0);
    bus_if.data_in = 4'h0;
    for (int n = 0; n < 8; n++) begin
      bus_if.data_valid = 1'b1;
      tick();
      bus_if.data_valid = 1'b0;
      if (n < 7) begin
        tick();
        chk("t4_bubble_busy", 32'(bus_if.busy), 32'd1);
      end
    end
    chk("t4_pre_send_vld", 32'(bus_if.crc_out_vld), 32'd0);
    check_send(16'h0000, "t4");

    // 5: abort mid-DATA and restart; only the second block completes
    do_start(1'b1, 12'd2048);
    feed(100, 4'hF);
    do_start(1'b1, 12'd2048);
    chk("t5_abort_done", 32'(bus_if.crc_done), 32'd0);
    chk("t5_abort_busy", 32'(bus_if.busy), 32'd1);
    feed(4096, 4'hF);
    check_send(16'h7FA1, "t5");

    // 7: block_sz=1, two 0xF nibbles -> 16'h3063
    do_start(1'b1, 12'd1);
    feed(2, 4'hF);
    check_send(16'h3063, "t7");

    // 8: block_sz=0 write goes straight to SEND with zero CRC
    do_start(1'b1, 12'd0);
    chk("t8_busy", 32'(bus_if.busy), 32'd1);
    check_send(16'h0000, "t8");

    // 9: block_sz=0 read, correct zero CRC
    do_start(1'b0, 12'd0);
    recv_crc(16'h0000, -1, 4'h0, 1'b0, "t9");

    // 10: start on the cycle the last CRC nibble is shown suppresses crc_done
    do_start(1'b1, 12'd0);
    repeat (16) tick();
    chk("t10_last_vld", 32'(bus_if.crc_out_vld), 32'd1);
    do_start(1'b1, 12'd0);
    chk("t10_done_supp", 32'(bus_if.crc_done), 32'd0);
    chk("t10_busy", 32'(bus_if.busy), 32'd1);
    check_send(16'h0000, "t10");

    // 6: rst during SEND nibble 7
    do_start(1'b1, 12'd2048);
    feed(4096, 4'hF);
    repeat (7) tick();
    chk("t6_nib7", 32'(bus_if.crc_out), 32'hF);
    rst = 1'b1;
    tick();
    chk("t6_busy", 32'(bus_if.busy), 32'd0);
    chk("t6_vld", 32'(bus_if.crc_out_vld), 32'd0);
    chk("t6_out", 32'(bus_if.crc_out), 32'd0);
    chk("t6_err", 32'(bus_if.crc_err), 32'd0);
    chk("t6_done", 32'(bus_if.crc_done), 32'd0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
